// File: rtl/jam_param_if.sv
// Host-side bundle for jam_param: run control, cost-memory address/data and result strobe.
interface jam_param_if #(
    parameter int CW = 7
);
    logic            START;
    logic            MODE;
    logic [2:0]      W;
    logic [2:0]      J;
    logic [CW-1:0]   Cost;
    logic [CW+2:0]   MinCost;
    logic [15:0]     MatchCount;
    logic            Valid;
    logic            Busy;

    modport master (
        output START, MODE, Cost,
        input  W, J, MinCost, MatchCount, Valid, Busy
    );

    modport slave (
        input  START, MODE, Cost,
        output W, J, MinCost, MatchCount, Valid, Busy
    );
endinterface

// File: rtl/jam_param.sv
// Exhaustive N x N job-assignment solver: loads the cost matrix, then scores one
// permutation per clock in lexicographic order and reports the optimum and its multiplicity.
module jam_param #(
    parameter int N  = 8,
    parameter int CW = 7
) (
    input  logic     CLK,
    input  logic     RST,
    jam_param_if.slave bus
);
    localparam int unsigned NU = N;
    localparam int          SW = CW + 3;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t          state, state_n;
    logic [2:0]      w_q, j_q;
    logic            mode_q;
    logic [CW-1:0]   mem [8][8];
    logic [2:0]      perm [8];
    logic [2:0]      perm_n [8];
    logic [SW-1:0]   best, best_n, sum, min_q;
    logic [15:0]     count, count_n, match_q;
    logic            last_addr, last_perm, found, better;
    logic [2:0]      piv, swp;
    logic [3:0]      rr;

    assign last_addr = (w_q == 3'(N - 1)) && (j_q == 3'(N - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.START) state_n = LOAD;
            LOAD:    if (last_addr) state_n = RUN;
            RUN:     if (last_perm) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < NU; i++)
            sum = sum + SW'(mem[3'(i)][perm[3'(i)]]);
    end

    always_comb begin
        better  = mode_q ? (sum > best) : (sum < best);
        best_n  = best;
        count_n = count;
        if (better) begin
            best_n  = sum;
            count_n = 16'd1;
        end else if (sum == best) begin
            count_n = count + 16'd1;
        end
    end

    // Lexicographic successor: swap pivot with rightmost larger element, then reverse the tail.
    // Tail position k reads from mirrored index N+piv-k, substituting the old pivot where the swap landed.
    always_comb begin
        found = 1'b0;
        piv   = '0;
        swp   = '0;
        rr    = '0;
        for (int unsigned i = 0; i + 1 < NU; i++)
            if (perm[3'(i)] < perm[3'(i + 1)]) begin
                found = 1'b1;
                piv   = 3'(i);
            end
        for (int unsigned k = 0; k < NU; k++)
            if (3'(k) > piv && perm[3'(k)] > perm[piv]) swp = 3'(k);
        perm_n = perm;
        for (int unsigned k = 0; k < NU; k++) begin
            if (3'(k) == piv) begin
                perm_n[3'(k)] = perm[swp];
            end else if (3'(k) > piv) begin
                rr = 4'(NU) + {1'b0, piv} - 4'(k);
                perm_n[3'(k)] = (rr[2:0] == swp) ? perm[piv] : perm[rr[2:0]];
            end
        end
        last_perm = !found;
    end

    always_ff @(posedge CLK) begin
        if (state == LOAD) mem[w_q][j_q] <= bus.Cost;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            w_q     <= '0;
            j_q     <= '0;
            mode_q  <= 1'b0;
            best    <= '0;
            count   <= '0;
            min_q   <= '0;
            match_q <= '0;
            for (int unsigned k = 0; k < 8; k++) perm[k] <= 3'(k);
        end else begin
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        w_q    <= '0;
                        j_q    <= '0;
                        mode_q <= bus.MODE;
                    end
                end
                LOAD: begin
                    if (j_q == 3'(N - 1)) begin
                        j_q <= '0;
                        w_q <= last_addr ? '0 : w_q + 3'd1;
                    end else begin
                        j_q <= j_q + 3'd1;
                    end
                    if (last_addr) begin
                        for (int unsigned k = 0; k < 8; k++) perm[k] <= 3'(k);
                        best  <= mode_q ? '0 : '1;
                        count <= '0;
                    end
                end
                RUN: begin
                    best  <= best_n;
                    count <= count_n;
                    if (last_perm) begin
                        min_q   <= best_n;
                        match_q <= count_n;
                    end else begin
                        perm <= perm_n;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.W          = w_q;
    assign bus.J          = j_q;
    assign bus.MinCost    = min_q;
    assign bus.MatchCount = match_q;
    assign bus.Valid      = (state == DONE);
    assign bus.Busy       = (state == LOAD) || (state == RUN);
endmodule

// File: tb/tb_jam_param.sv
// Bench for jam_param: four instances (N=3, 4, 8, 8) checked every cycle against a
// brute-force assignment model plus literal expectations from hand-worked matrices.
module tb_jam_param;
    localparam int NI = 4;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    logic        start_v [NI];
    logic        mode_v  [NI];
    int          cost    [NI][8][8];
    logic [2:0]  o_w     [NI];
    logic [2:0]  o_j     [NI];
    logic [9:0]  o_mc    [NI];
    logic [15:0] o_cnt   [NI];
    logic        o_vld   [NI];
    logic        o_busy  [NI];

    int checks   = 0;
    int failures = 0;

    function automatic int nof(input int g);
        return (g == 0) ? 3 : (g == 1) ? 4 : 8;
    endfunction

    function automatic int fact(input int n);
        int f;
        f = 1;
        for (int i = 2; i <= n; i++) f = f * i;
        return f;
    endfunction

    function automatic int run_len(input int g);
        return nof(g) * nof(g) + fact(nof(g));
    endfunction

    task automatic chk(input string nm, input int g, input longint a, input longint e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s inst%0d got=%0d expected=%0d t=%0t", nm, g, a, e, $time);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int NN = (g == 0) ? 3 : (g == 1) ? 4 : 8;
        jam_param_if #(.CW(7)) bus ();
        jam_param #(.N(NN), .CW(7)) dut (.CLK(CLK), .RST(RST), .bus(bus));
        assign bus.START = start_v[g];
        assign bus.MODE  = mode_v[g];
        assign bus.Cost  = 7'(cost[g][bus.W][bus.J]);
        assign o_w[g]    = bus.W;
        assign o_j[g]    = bus.J;
        assign o_mc[g]   = bus.MinCost;
        assign o_cnt[g]  = bus.MatchCount;
        assign o_vld[g]  = bus.Valid;
        assign o_busy[g] = bus.Busy;
    end

    // Enumerate every assignment by decoding its factorial-base rank.
    task automatic brute(input int g, input logic md, output int b, output int c);
        int n, r, d, s, f;
        bit used [8];
        n = nof(g);
        b = md ? -1 : (1 << 30);
        c = 0;
        for (int idx = 0; idx < fact(n); idx++) begin
            r = idx;
            s = 0;
            for (int k = 0; k < 8; k++) used[k] = 1'b0;
            for (int i = 0; i < n; i++) begin
                f = fact(n - 1 - i);
                d = r / f;
                r = r % f;
                for (int k = 0; k < n; k++) begin
                    if (!used[k]) begin
                        if (d == 0) begin
                            used[k] = 1'b1;
                            s = s + cost[g][i][k];
                            d = -1;
                        end else if (d > 0) begin
                            d = d - 1;
                        end
                    end
                end
            end
            if (md ? (s > b) : (s < b)) begin
                b = s;
                c = 1;
            end else if (s == b) begin
                c = c + 1;
            end
        end
    endtask

    // Model: m_p counts edges since the accepted START edge; L edges later the result is visible.
    int m_act [NI];
    int m_p   [NI];
    int m_best[NI];
    int m_cnt [NI];
    int h_mc  [NI];
    int h_cnt [NI];

    always @(posedge CLK or posedge RST) begin
        for (int g = 0; g < NI; g++) begin
            if (RST) begin
                m_act[g] = 0;
                m_p[g]   = 0;
                h_mc[g]  = 0;
                h_cnt[g] = 0;
            end else if (m_act[g] != 0) begin
                if (m_p[g] == run_len(g)) begin
                    m_act[g] = 0;
                end else begin
                    m_p[g] = m_p[g] + 1;
                    if (m_p[g] == run_len(g)) begin
                        h_mc[g]  = m_best[g];
                        h_cnt[g] = m_cnt[g];
                    end
                end
            end else if (start_v[g]) begin
                m_act[g] = 1;
                m_p[g]   = 0;
                brute(g, mode_v[g], m_best[g], m_cnt[g]);
            end
        end
    end

    always @(negedge CLK) begin
        for (int g = 0; g < NI; g++) begin
            int n, L, p, ew, ej;
            bit act;
            n   = nof(g);
            L   = run_len(g);
            p   = m_p[g];
            act = (m_act[g] != 0);
            ew  = (act && p < n * n) ? p / n : 0;
            ej  = (act && p < n * n) ? p % n : 0;
            chk("busy",  g, o_busy[g], (act && p < L) ? 1 : 0);
            chk("valid", g, o_vld[g],  (act && p == L) ? 1 : 0);
            chk("w",     g, o_w[g],    ew);
            chk("j",     g, o_j[g],    ej);
            chk("mincost",    g, o_mc[g],  h_mc[g]);
            chk("matchcount", g, o_cnt[g], h_cnt[g]);
        end
    end

    task automatic run_job(input int g, input logic md, input bit glitch,
                           output int lat, output int busy_n);
        int limit;
        limit = run_len(g) + 5;
        @(negedge CLK);
        start_v[g] = 1'b1;
        mode_v[g]  = md;
        @(negedge CLK);
        start_v[g] = 1'b0;
        mode_v[g]  = ~md;
        lat    = 0;
        busy_n = 0;
        while (!o_vld[g] && lat < limit) begin
            if (o_busy[g]) busy_n++;
            @(negedge CLK);
            lat++;
            start_v[g] = glitch && (lat == 20);
            mode_v[g]  = 1'($urandom_range(1));
        end
        start_v[g] = 1'b0;
        chk("valid_seen", g, o_vld[g], 1);
    endtask

    task automatic summary;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        summary();
        $fatal(1);
    end

    initial begin
        int lat, bn, lat8a, lat8b, bn8;
        for (int g = 0; g < NI; g++) begin
            start_v[g] = 1'b0;
            mode_v[g]  = 1'b0;
        end
        #1 RST = 1'b1;
        repeat (3) @(negedge CLK);
        for (int g = 0; g < NI; g++) begin
            chk("rst_mincost", g, o_mc[g], 0);
            chk("rst_count",   g, o_cnt[g], 0);
            chk("rst_valid",   g, o_vld[g], 0);
            chk("rst_busy",    g, o_busy[g], 0);
        end
        RST = 1'b0;

        // N=3, cost w+j: every assignment totals 6
        for (int w = 0; w < 3; w++) for (int j = 0; j < 3; j++) cost[0][w][j] = w + j;
        run_job(0, 1'b0, 1'b0, lat, bn);
        chk("lat_n3", 0, lat, 15);
        chk("n3_mincost", 0, o_mc[0], 6);
        chk("n3_count",   0, o_cnt[0], 6);
        chk("model_n3_best", 0, m_best[0], 6);
        // Back-to-back: new matrix, START in the cycle after Valid
        for (int w = 0; w < 3; w++) for (int j = 0; j < 3; j++) cost[0][w][j] = 7 * w + 3 * j + (w * j) % 5;
        run_job(0, 1'b1, 1'b0, lat, bn);
        chk("lat_n3b", 0, lat, 15);

        // N=4 diagonal zero, ten elsewhere
        for (int w = 0; w < 4; w++) for (int j = 0; j < 4; j++) cost[1][w][j] = (w == j) ? 0 : 10;
        run_job(1, 1'b0, 1'b0, lat, bn);
        chk("n4_min",       1, o_mc[1], 0);
        chk("n4_min_count", 1, o_cnt[1], 1);
        run_job(1, 1'b1, 1'b1, lat, bn);
        chk("lat_n4", 1, lat, 40);
        chk("n4_max",       1, o_mc[1], 40);
        chk("n4_max_count", 1, o_cnt[1], 9);
        chk("model_n4_derange", 1, m_cnt[1], 9);

        // Asynchronous reset mid-RUN, then a clean rerun
        for (int w = 0; w < 4; w++) for (int j = 0; j < 4; j++) cost[1][w][j] = $urandom_range(127);
        @(negedge CLK);
        start_v[1] = 1'b1;
        @(negedge CLK);
        start_v[1] = 1'b0;
        repeat (25) @(negedge CLK);
        #3 RST = 1'b1;
        #1;
        chk("arst_mincost", 1, o_mc[1], 0);
        chk("arst_count",   1, o_cnt[1], 0);
        chk("arst_valid",   1, o_vld[1], 0);
        chk("arst_busy",    1, o_busy[1], 0);
        @(negedge CLK);
        RST = 1'b0;
        run_job(1, 1'($urandom_range(1)), 1'b0, lat, bn);
        chk("lat_n4_after_rst", 1, lat, 40);

        for (int w = 0; w < 8; w++) for (int j = 0; j < 8; j++) begin
            cost[2][w][j] = 127;
            cost[3][w][j] = (7 - j) * (w + 1);
        end
        fork
            begin
                run_job(2, 1'b0, 1'b0, lat8a, bn);
            end
            begin
                run_job(3, 1'b0, 1'b0, lat8b, bn8);
            end
            begin
                for (int r = 0; r < 30; r++) begin
                    int l3, b3;
                    for (int w = 0; w < 3; w++) for (int j = 0; j < 3; j++) cost[0][w][j] = $urandom_range(127);
                    run_job(0, 1'($urandom_range(1)), 1'b0, l3, b3);
                    chk("lat_n3_rand", 0, l3, 15);
                end
            end
            begin
                for (int r = 0; r < 20; r++) begin
                    int l4, b4;
                    for (int w = 0; w < 4; w++) for (int j = 0; j < 4; j++) cost[1][w][j] = $urandom_range(127);
                    run_job(1, 1'($urandom_range(1)), 1'($urandom_range(1)), l4, b4);
                    chk("lat_n4_rand", 1, l4, 40);
                end
            end
        join
        chk("lat_n8a", 2, lat8a, 40384);
        chk("n8_all127_min",   2, o_mc[2], 1016);
        chk("n8_all127_count", 2, o_cnt[2], 40320);
        chk("lat_n8b", 3, lat8b, 40384);
        chk("n8_busy_cycles",  3, bn8, 64 + 40320);
        chk("n8_ramp_min",     3, o_mc[3], 84);
        chk("n8_ramp_count",   3, o_cnt[3], 1);
        chk("model_n8_ramp",   3, m_best[3], 84);

        repeat (3) @(negedge CLK);
        summary();
        $finish;
    end
endmodule

// File: doc/jam_param.md
# jam_param

Parametrised job-assignment solver for an N-worker × N-job cost matrix, with N from 2 to 8. On a START pulse it reads the full cost matrix from an external cost memory through the W/J address outputs. It then scores every one of the N! assignments in ascending lexicographic permutation order, at one permutation per clock, and reports the optimal total cost and how many assignments achieve it. A MODE input selects minimisation or maximisation. The block sits beside the cost ROM/testfixture and can be re-run without reset.

## Interface
- N, 8, workers = jobs; legal range 2..8.
- CW, 7, cost word width.
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  run request; sampled only in IDLE.
- MODE  input  1  0 = minimise, 1 = maximise; sampled with START and held internally for the run.
- W  output  3  worker index of the requested cost word; values 0..N-1.
- J  output  3  job index of the requested cost word; values 0..N-1.
- Cost  input  CW  cost[W][J]; the source drives it combinationally from the current W/J.
- MinCost  output  CW+3  optimal total cost, named MinCost in both modes.
- MatchCount  output  16  number of permutations achieving MinCost.
- Valid  output  1  one-cycle result strobe.
- Busy  output  1  high in LOAD and RUN.

## Operation
- States: IDLE → LOAD → RUN → DONE → IDLE.
- IDLE: START=1 → LOAD, W=0, J=0, latch MODE. Otherwise hold state.
- LOAD: each edge captures Cost into mem[W][J].
  - If J<N-1, J+1. Else J=0 and W+1.
  - The edge capturing (N-1,N-1) → RUN, with W/J returning to 0.
  - Also on that edge: perm[i]=i; best = all-ones if MODE=0, 0 if MODE=1; count=0.
- RUN: each edge scores the current permutation.
  - sum = Σ mem[i][perm[i]] over i=0..N-1; width CW+3, no overflow possible for N≤8.
  - If sum better than best (strictly < for MODE=0, strictly > for MODE=1): best=sum, count=1.
  - Else if sum==best: count+1.
  - Same edge advances perm to the lexicographic successor:
    - pivot i = largest index with perm[i]<perm[i+1];
    - j = largest index >i with perm[j]>perm[i];
    - swap perm[i]/perm[j], then reverse perm[i+1..N-1].
  - If perm is fully descending, it is the last permutation: score it, then → DONE instead of advancing.
- DONE: MinCost=best, MatchCount=count, Valid=1 for this cycle only → IDLE.
- MinCost/MatchCount hold until the next DONE.
- START while Busy or in DONE: ignored, no queuing.
- MODE changes after START have no effect on the current run.
- Positions ≥N of perm/mem are unused and never addressed; W/J never exceed N-1.
- Reset (any time, including mid-LOAD/RUN): state=IDLE, W=0, J=0, MinCost=0, MatchCount=0, Valid=0, Busy=0, perm=identity, best=0, count=0; the partial run is discarded.

## Timing
- START sampled at edge t0. LOAD captures on edges t1..t(N²). RUN scores on edges t(N²+1)..t(N²+N!).
- Valid high for the cycle after edge t(N²+N!). Outputs are already updated when Valid rises.
- Total START→Valid latency: N²+N! edges (N=4: 40; N=8: 40384).
- Busy rises after t0 and falls at edge t(N²+N!).
- Cost must be stable before each rising edge for the W/J present that cycle; one address per cycle, no stalls.
- Back-to-back runs: START may be high in the cycle after Valid (IDLE); minimum period N²+N!+2 cycles.

## Test plan
- N=3, MODE=0, cost[w][j]=w+j → every sum is 6; MinCost=6, MatchCount=6, Valid exactly 9+6 edges after START.
- N=4, cost=0 on the diagonal, 10 elsewhere. MODE=0 → MinCost=0, MatchCount=1. Rerun with MODE=1 → MinCost=40, MatchCount=9 (derangements).
- N=8, all costs 127, MODE=0 → MinCost=1016, MatchCount=40320; checks no width overflow.
- N=8, cost[w][j]=(7-j)*(w+1), MODE=0 → MinCost equals the bench's brute-force result, MatchCount=1; also check the W/J scan order 0..63 and that Busy stays high for 64+40320 cycles.
- Pulse START again mid-RUN (N=4) → ignored, single Valid, results unchanged. Assert RST mid-RUN → MinCost=0, MatchCount=0, Valid=0 immediately (asynchronous). A subsequent START produces the correct result.
- Two consecutive runs (N=3) with different matrices and START the cycle after Valid → each Valid carries its own matrix's result; W/J restart at 0.
